pc_fetch_gen: RTL and testbench

Parametrised PC generator and instruction-fetch front end. It drives fetch requests to the instruction memory over a req/gnt/rvalid bus and tracks up to DEPTH outstanding requests in an address FIFO. On a jump it discards stale responses and redirects the PC. It sits between the EX-stage jump interface and the instruction memory, and feeds if_id with tagged instructions.

---
 rtl/pc_fetch_gen_pkg.sv | 17 +
 rtl/pc_fetch_fifo.sv | 88 ++++++++
 rtl/pc_fetch_gen.sv | 114 +++++++++++
 tb/tb_pc_fetch_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants and state encoding for the PC generator / fetch front end.
package pc_fetch_gen_pkg;

    localparam logic RstEnable  = 1'b0;
    localparam logic JumpEnable = 1'b1;

    localparam int unsigned FetchAddrW = 32;
    localparam logic [31:0] ResetPc    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTING = 2'd2,
        HALTED  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_fifo.sv
// In-order tracker of outstanding fetch addresses, each tagged with a stale bit
// so responses belonging to a redirected stream can be dropped.
module pc_fetch_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              push_stale_i,
    input  logic              pop_i,
    input  logic              mark_stale_i,
    output logic [CntW-1:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic              head_stale_o
);

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic              stale_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o       = (count_q == CntW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_stale_o = stale_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A same-cycle push wins over the broadcast mark; the caller sets its stale bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i]  <= '0;
                stale_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push_ok && (wr_ptr_q == PtrW'(i))) begin
                    addr_q[i]  <= push_addr_i;
                    stale_q[i] <= push_stale_i;
                end else if (mark_stale_i) begin
                    stale_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pc_fetch_gen.sv
// PC generator and instruction-fetch front end: issues req/gnt fetches,
// tracks outstanding requests and filters responses made stale by jumps.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FetchAddrW,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ResetPc),
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    input  logic              halt_req_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [31:0]       rdata_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              misalign_o,
    output logic              halted_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              misalign_q, misalign_d;

    logic [CntW-1:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic              head_stale;
    logic              jump_act;
    logic              push;
    logic              pop;
    logic              next_empty;

    assign jump_act = (jump_flag_i == JumpEnable) && (state_q != IDLE);
    assign req_o    = (state_q == RUN) && !hold_flag_i && !fifo_full;
    assign push     = req_o && gnt_i;
    assign pop      = rvalid_i && !fifo_empty;

    // FIFO occupancy after this edge, so halting completes on the last response.
    assign next_empty = ((fifo_count == '0) && !push) ||
                        ((fifo_count == CntW'(1)) && pop && !push);

    pc_fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .push_i       (push),
        .push_addr_i  (addr_q),
        .push_stale_i (jump_act),
        .pop_i        (pop),
        .mark_stale_i (jump_act),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_addr_o  (head_addr),
        .head_stale_o (head_stale)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        misalign_d = 1'b0;

        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt_req_i) state_d = next_empty ? HALTED : HALTING;
            HALTING: begin
                if (!halt_req_i)     state_d = RUN;
                else if (next_empty) state_d = HALTED;
            end
            HALTED:  if (!halt_req_i) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (jump_act) begin
            addr_d     = {jump_addr_i[ADDR_W-1:2], 2'b00};
            misalign_d = |jump_addr_i[1:0];
        end else if (push) begin
            addr_d = addr_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            misalign_q <= misalign_d;
        end
    end

    assign addr_o       = addr_q;
    assign misalign_o   = misalign_q;
    assign halted_o     = (state_q == HALTED);
    assign inst_o       = rdata_i;
    assign inst_addr_o  = head_addr;
    assign inst_valid_o = rvalid_i && !fifo_empty && !head_stale && !jump_flag_i;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen with hand-computed expectations.
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        halt_req_i;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        misalign_o;
    logic        halted_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_gen dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .halt_req_i   (halt_req_i),
        .req_o        (req_o),
        .addr_o       (addr_o),
        .gnt_i        (gnt_i),
        .rvalid_i     (rvalid_i),
        .rdata_i      (rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .misalign_o   (misalign_o),
        .halted_o     (halted_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven afterwards are stable well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jump_flag_i = 1'b0;
        jump_addr_i = 32'h0;
        hold_flag_i = 1'b0;
        halt_req_i  = 1'b0;
        gnt_i       = 1'b0;
        rvalid_i    = 1'b0;
        rdata_i     = 32'h0;
    endtask

    // Leaves the DUT in RUN with addr_o = 0 and an empty FIFO.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #2;
        check_eq("rst_addr",     addr_o,       32'h0);
        check_eq("rst_req",      32'(req_o),   32'h0);
        check_eq("rst_ivalid",   32'(inst_valid_o), 32'h0);
        check_eq("rst_misalign", 32'(misalign_o),   32'h0);
        check_eq("rst_halted",   32'(halted_o),     32'h0);

        // Streaming: gnt every cycle, response one cycle after each grant.
        tick();
        rst = 1'b1;
        gnt_i = 1'b1;
        #1;
        check_eq("idle_no_req", 32'(req_o), 32'h0);
        tick();
        check_eq("s_req0",  32'(req_o), 32'h1);
        check_eq("s_addr0", addr_o,     32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            rvalid_i = 1'b1;
            rdata_i  = 32'hA000_0000 + 32'(k);
            #1;
            check_eq("s_addr",   addr_o,              32'(4 * (k + 1)));
            check_eq("s_ivalid", 32'(inst_valid_o),   32'h1);
            check_eq("s_iaddr",  inst_addr_o,         32'(4 * k));
            check_eq("s_inst",   inst_o,              32'hA000_0000 + 32'(k));
        end

        // Backpressure: FIFO fills after two grants.
        do_reset();
        gnt_i = 1'b1;
        tick();
        tick();
        check_eq("full_req",  32'(req_o), 32'h0);
        check_eq("full_addr", addr_o,     32'h8);
        tick();
        check_eq("full_hold_addr", addr_o, 32'h8);
        rvalid_i = 1'b1;
        rdata_i  = 32'h1111_0000;
        #1;
        check_eq("full_ivalid", 32'(inst_valid_o), 32'h1);
        check_eq("full_iaddr",  inst_addr_o,       32'h0);
        tick();
        rvalid_i = 1'b0;
        #1;
        check_eq("full_req_resume", 32'(req_o), 32'h1);
        check_eq("full_addr_resume", addr_o,    32'h8);

        // Jump with two outstanding: both responses dropped, 0x100 delivered.
        do_reset();
        gnt_i = 1'b1;
        tick();
        tick();
        gnt_i = 1'b0;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h100;
        tick();
        jump_flag_i = 1'b0;
        rvalid_i = 1'b1;
        #1;
        check_eq("j_addr",    addr_o,              32'h100);
        check_eq("j_drop0",   32'(inst_valid_o),   32'h0);
        check_eq("j_misal0",  32'(misalign_o),     32'h0);
        tick();
        gnt_i = 1'b1;
        #1;
        check_eq("j_drop1",   32'(inst_valid_o),   32'h0);
        check_eq("j_req",     32'(req_o),          32'h1);
        tick();
        gnt_i   = 1'b0;
        rdata_i = 32'hBEEF_0100;
        #1;
        check_eq("j_ivalid",  32'(inst_valid_o),   32'h1);
        check_eq("j_iaddr",   inst_addr_o,         32'h100);
        check_eq("j_inst",    inst_o,              32'hBEEF_0100);
        check_eq("j_addr2",   addr_o,              32'h104);

        // Misaligned target, ungranted hold, stray rvalid, and jump-cycle suppression.
        do_reset();
        rvalid_i = 1'b1;
        #1;
        check_eq("stray_rvalid", 32'(inst_valid_o), 32'h0);
        rvalid_i    = 1'b0;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h203;
        #1;
        check_eq("m_pre", 32'(misalign_o), 32'h0);
        tick();
        jump_flag_i = 1'b0;
        #1;
        check_eq("m_addr",  addr_o,          32'h200);
        check_eq("m_pulse", 32'(misalign_o), 32'h1);
        tick();
        check_eq("m_clear",   32'(misalign_o), 32'h0);
        check_eq("ungnt_addr", addr_o,         32'h200);
        gnt_i = 1'b1;
        tick();
        gnt_i       = 1'b0;
        rvalid_i    = 1'b1;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h300;
        #1;
        check_eq("jump_cycle_suppress", 32'(inst_valid_o), 32'h0);
        tick();
        clear_inputs();

        // Hold stalls requests; a jump still redirects during hold.
        do_reset();
        gnt_i = 1'b1;
        hold_flag_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("h_req",  32'(req_o), 32'h0);
            check_eq("h_addr", addr_o,     32'h0);
            tick();
        end
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h40;
        tick();
        jump_flag_i = 1'b0;
        #1;
        check_eq("h_jaddr", addr_o,     32'h40);
        check_eq("h_jreq",  32'(req_o), 32'h0);

        // Halt with one outstanding request.
        do_reset();
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        halt_req_i = 1'b1;
        tick();
        check_eq("hl_req",     32'(req_o),    32'h0);
        check_eq("hl_halted0", 32'(halted_o), 32'h0);
        rvalid_i = 1'b1;
        #1;
        check_eq("hl_ivalid",  32'(inst_valid_o), 32'h1);
        check_eq("hl_halted1", 32'(halted_o),     32'h0);
        tick();
        rvalid_i = 1'b0;
        #1;
        check_eq("hl_halted2", 32'(halted_o), 32'h1);
        check_eq("hl_req2",    32'(req_o),    32'h0);
        halt_req_i = 1'b0;
        tick();
        check_eq("hl_resume_req",    32'(req_o),    32'h1);
        check_eq("hl_resume_halted", 32'(halted_o), 32'h0);

        // Asynchronous reset while HALTING.
        do_reset();
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        halt_req_i = 1'b1;
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h203;
        tick();
        jump_flag_i = 1'b0;
        #1;
        check_eq("ar_pre_addr",  addr_o,          32'h200);
        check_eq("ar_pre_mis",   32'(misalign_o), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("ar_addr",   addr_o,            32'h0);
        check_eq("ar_mis",    32'(misalign_o),   32'h0);
        check_eq("ar_req",    32'(req_o),        32'h0);
        check_eq("ar_halted", 32'(halted_o),     32'h0);
        rvalid_i = 1'b1;
        #1;
        check_eq("ar_ivalid", 32'(inst_valid_o), 32'h0);
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
